// File: rtl/display_timing_controller_pkg.sv
// Shared timing defaults, counter width and FSM state encoding for the
// display timing controller and its line counter.
package display_timing_controller_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_TOTAL  = 800;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_TOTAL  = 525;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dtc_state_e;

endpackage

// File: rtl/display_timing_controller_linecounter.sv
// Line counter with the same synchronous clear / increment controls as the
// external pixel counter; clear has priority over increment.
module linecounter
  import display_timing_controller_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Line index register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 10'd0;
    end else if (clear) begin
      count <= 10'd0;
    end else if (inc) begin
      count <= count + 10'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/display_timing_controller.sv
// Display timing controller: drives an external pixel counter, owns the line
// counter, and derives de/hsync/vsync, pixel handshake and underrun flag.
module display_timing_controller
  import display_timing_controller_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_TOTAL  = DEF_V_TOTAL
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] px_count,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             ResetPx,
  output logic             IncPx,
  output logic [CNT_W-1:0] line,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             underrun,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_END_C  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_END_C  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  dtc_state_e state_r, state_next_s;
  logic       eol_s, frame_end_s, line_clear_s, line_inc_s;

  // Out-of-range counts are treated as end of line so the counter recovers
  assign eol_s       = (px_count >= H_END_C);
  assign frame_end_s = eol_s && (line == V_END_C);

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: leave RUN only at a frame boundary so frames are never cut
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_next_s = ST_RUN;
        else        state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (frame_end_s && !enable) state_next_s = ST_IDLE;
        else                        state_next_s = ST_RUN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Counter controls and video timing outputs
  always_comb begin
    ResetPx      = 1'b1;
    IncPx        = 1'b0;
    de           = 1'b0;
    hsync        = 1'b1;
    vsync        = 1'b1;
    frame_done   = 1'b0;
    line_clear_s = 1'b1;
    line_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ResetPx      = 1'b1;
        line_clear_s = 1'b1;
      end
      ST_RUN: begin
        ResetPx      = eol_s;
        IncPx        = !eol_s;
        line_inc_s   = eol_s;
        line_clear_s = frame_end_s;
        frame_done   = frame_end_s;
        de           = (px_count < H_ACT_C) && (line < V_ACT_C);
        hsync        = !((px_count >= HS_BEG_C) && (px_count < HS_END_C));
        vsync        = !((line >= VS_BEG_C) && (line < VS_END_C));
      end
      default: begin
        ResetPx      = 1'b1;
        line_clear_s = 1'b1;
      end
    endcase
  end

  assign pix_ready = de;

  // Sticky underrun: an active slot passed without a pixel
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
    end else if (de && !pix_valid) begin
      underrun <= 1'b1;
    end else begin
      underrun <= underrun;
    end
  end

  linecounter u_linecounter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (line_clear_s),
    .inc     (line_inc_s),
    .count   (line)
  );

endmodule

// File: doc/display_timing_controller.md
DISPLAY_TIMING_CONTROLLER -- requirements
Module: display_timing_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  H_ACTIVE  640  visible pixels per line
  H_FP  16  horizontal front porch, pixels
  H_SYNC  96  hsync pulse width, pixels
  H_TOTAL  800  pixels per line, all regions
  V_ACTIVE  480  visible lines per frame
  V_FP  10  vertical front porch, lines
  V_SYNC  2  vsync pulse width, lines
  V_TOTAL  525  lines per frame
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock  in  1  single clock, all logic on posedge
  reset_n  in  1  asynchronous, active-low reset
  enable  in  1  run frames while high
  px_count  in  10  current value of the external pixel counter (its PxOut)
  pix_valid  in  1  pixel source has a pixel available
  pix_ready  out  1  controller accepts a pixel this cycle
  ResetPx  out  1  synchronous clear to pixel counter
  IncPx  out  1  increment strobe to pixel counter
  line  out  10  current line index
  de  out  1  display enable, active region
  hsync  out  1  horizontal sync, active-low
  vsync  out  1  vertical sync, active-low
  underrun  out  1  sticky: active pixel slot had no valid pixel
  frame_done  out  1  one-cycle pulse at frame end

Function
REQ-003 FSM SHALL have states IDLE and RUN; reset enters IDLE.
REQ-004 IDLE: ResetPx=1, IncPx=0, line held 0, de=0, pix_ready=0, hsync=vsync=1.
REQ-005 IDLE->RUN on the first clock edge with enable=1; px_count is 0 in the first RUN cycle.
REQ-006 RUN, px_count < H_TOTAL-1: IncPx=1, ResetPx=0.
REQ-007 RUN, px_count == H_TOTAL-1: IncPx=0, ResetPx=1; line increments at the same edge.
REQ-008 End of frame (px_count==H_TOTAL-1 and line==V_TOTAL-1): line wraps to 0; frame_done=1 for that cycle.
REQ-009 At end of frame, enable=0 -> IDLE; enable=1 -> stay in RUN, next frame starts without a gap. Deasserting enable mid-frame SHALL NOT truncate the frame.
REQ-010 de = RUN and px_count < H_ACTIVE and line < V_ACTIVE; this is a combinational function of the current state, px_count and line.
REQ-011 pix_ready SHALL equal de; a pixel is transferred iff pix_ready and pix_valid are both 1 in the same cycle.
REQ-012 hsync=0 iff RUN and H_ACTIVE+H_FP <= px_count < H_ACTIVE+H_FP+H_SYNC.
REQ-013 vsync=0 iff RUN and V_ACTIVE+V_FP <= line < V_ACTIVE+V_FP+V_SYNC.
REQ-014 underrun SHALL set on any cycle with de=1 and pix_valid=0; it stays set until reset, and timing continues unchanged.
REQ-015 Timing SHALL never stall on pix_valid.
REQ-016 Any px_count >= H_TOTAL in RUN is treated as end of line (ResetPx=1).
REQ-017 All comparisons SHALL be 10-bit unsigned; parameters must fit in 10 bits.

Reset
REQ-018 reset_n=0 SHALL asynchronously force IDLE, line=0, underrun=0, frame_done=0; the outputs then follow REQ-004.
REQ-019 Reset asserted mid-frame SHALL abandon the frame; after release the first frame starts at line 0, px_count 0.

Structure
REQ-020 The default timing constants and the FSM state encoding SHALL live in a shared display timing package.
REQ-021 The line counter SHALL be a sub-module, linecounter, with the same clear/increment style as the pixel counter.
REQ-022 The pixel counter stays external; this block only drives its controls and reads px_count back.

Verification
Test parameters: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_TOTAL=8, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_TOTAL=6, paired with a real pixel counter.
REQ-023 Reset release, enable=1 -> px_count runs 0..7, ResetPx=1 at px_count=7, line runs 0..5 and wraps; frame_done pulses once per 48 cycles.
REQ-024 Line 0 -> de=1 at px_count 0..3; hsync=0 at px_count 5..6; vsync=0 only on line 4.
REQ-025 pix_valid=1 constantly -> exactly 12 transfers per frame, underrun stays 0.
REQ-026 pix_valid=0 at line 1, px_count 2 -> underrun=1 from the next cycle and stays set; frame_done timing unchanged.
REQ-027 enable dropped at line 2 -> frame completes to line 5, then IDLE with ResetPx=1; re-enable restarts at line 0.
REQ-028 reset_n pulsed low at line 3, px_count 4 -> immediate IDLE, line=0, underrun=0; clean frame after release.
